// File: rtl/hex7seg_scan.sv
// Time-multiplexed driver for a bank of common-anode 7-segment digits sharing one segment bus.
// Scans digits round-robin, snapshotting the value once per frame so a digit never tears mid-scan.
module hex7seg_scan #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_BITS  = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  input  logic [DIGITS-1:0]     blink_en,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [PRE_W-1:0]      presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BLINK_BITS-1:0] blink_q, blink_d;
  logic [4*DIGITS-1:0]   snap_val_q, snap_val_d;
  logic [DIGITS-1:0]     snap_dp_q, snap_dp_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic                  fd_q, fd_d;

  logic                  tick;
  logic                  last_digit;
  logic [4*DIGITS-1:0]   upper;
  logic [3:0]            nib;
  logic                  lz_blank;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h01;
      4'h1: glyph = 7'h4F;
      4'h2: glyph = 7'h12;
      4'h3: glyph = 7'h06;
      4'h4: glyph = 7'h4C;
      4'h5: glyph = 7'h24;
      4'h6: glyph = 7'h20;
      4'h7: glyph = 7'h0F;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h04;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h60;
      4'hC: glyph = 7'h31;
      4'hD: glyph = 7'h42;
      4'hE: glyph = 7'h30;
      default: glyph = 7'h38;
    endcase
  endfunction

  always_comb begin
    tick       = (presc_q == PRE_W'(REFRESH_DIV - 1));
    last_digit = (idx_q == IDX_W'(DIGITS - 1));
    // Nibbles idx..DIGITS-1 shifted down; all-zero means this digit is a leading zero.
    upper      = snap_val_q >> {idx_q, 2'b00};
    nib        = upper[3:0];
    lz_blank   = blank_lz && (idx_q != '0) && (upper == '0);

    presc_d    = presc_q;
    idx_d      = idx_q;
    blink_d    = blink_q;
    snap_val_d = snap_val_q;
    snap_dp_d  = snap_dp_q;
    fd_d       = 1'b0;
    seg_d      = 7'h7F;
    dp_d       = 1'b1;
    an_d       = '1;

    if (enable) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      blink_d = blink_q + 1'b1;
      if (tick) begin
        idx_d = last_digit ? '0 : idx_q + 1'b1;
        if (last_digit) begin
          snap_val_d = value;
          snap_dp_d  = dp_in;
          fd_d       = 1'b1;
        end
      end
      // Drive reflects the digit currently selected; it lands one cycle later with its anode.
      an_d  = ~(DIGITS'(1) << idx_q);
      seg_d = lz_blank ? 7'h7F : glyph(nib);
      dp_d  = ~snap_dp_q[idx_q];
      if (blink_q[BLINK_BITS-1] && blink_en[idx_q]) begin
        seg_d = 7'h7F;
        dp_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q    <= '0;
      idx_q      <= '0;
      blink_q    <= '0;
      snap_val_q <= '0;
      snap_dp_q  <= '0;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
      an_q       <= '1;
      fd_q       <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      blink_q    <= blink_d;
      snap_val_q <= snap_val_d;
      snap_dp_q  <= snap_dp_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
      fd_q       <= fd_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule
